// File: rtl/hbus_pkg.sv
// hbus_pkg: constants shared by the HyperBus register/read/write sequencers.
//   HBUS_DW / HBUS_CAW : pad word width and command-address width.
//   CA_*               : command-address bit positions.
//   ST_*               : sequencer state encodings.
//   cyc_cnt_w()        : width of the shared cycle down-counter.
//   ca_reg_wr_ok()     : true when a CA word encodes a register-space write.
package hbus_pkg;

    localparam int HBUS_DW  = 16;
    localparam int HBUS_CAW = 48;

    // Command-address bit positions.
    localparam int CA_RW    = 47;   // 1 = read, 0 = write
    localparam int CA_AS    = 46;   // 1 = register space, 0 = memory
    localparam int CA_BURST = 45;   // 1 = linear burst, 0 = wrapped

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_CSS  = 4'd1;
    localparam logic [3:0] ST_CA0  = 4'd2;
    localparam logic [3:0] ST_CA1  = 4'd3;
    localparam logic [3:0] ST_CA2  = 4'd4;
    localparam logic [3:0] ST_DATA = 4'd5;
    localparam logic [3:0] ST_HOLD = 4'd6;
    localparam logic [3:0] ST_CSHI = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    // One extra bit so a load of N-1 always fits for either count.
    function automatic int cyc_cnt_w(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

    function automatic logic ca_reg_wr_ok(input logic [HBUS_CAW-1:0] ca);
        return !ca[CA_RW] && ca[CA_AS];
    endfunction

endpackage

// File: rtl/hbus_wrreg_seq_if.sv
// hbus_wrreg_seq_if: arbiter <-> register-write sequencer bundle.
//   stm_start/stm_end : level request / completion handshake
//   casig, wrdata     : command-address and register value (sampled at launch)
//   csn, oe, oe_clk, datain : pad-side controls and word
//   err               : CA check failure flag
// Modports: master = arbiter side, slave = sequencer side.
interface hbus_wrreg_seq_if
    import hbus_pkg::*;
#(
    parameter int DW  = HBUS_DW,
    parameter int CAW = HBUS_CAW
) ();

    logic           stm_start;
    logic           stm_end;
    logic [CAW-1:0] casig;
    logic [DW-1:0]  wrdata;
    logic           csn;
    logic           oe;
    logic           oe_clk;
    logic [DW-1:0]  datain;
    logic           err;

    modport master (
        output stm_start, casig, wrdata,
        input  stm_end, csn, oe, oe_clk, datain, err
    );

    modport slave (
        input  stm_start, casig, wrdata,
        output stm_end, csn, oe, oe_clk, datain, err
    );

endinterface

// File: rtl/hbus_cyc_cnt.sv
// hbus_cyc_cnt: loadable down-counter with zero flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : load ld_val (takes priority over dec)
//   dec      : decrement; holds at zero (no wrap)
//   zero     : count is zero
module hbus_cyc_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= ld_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hbus_wrreg_seq.sv
// hbus_wrreg_seq: HyperRAM config-register write sequencer.
// Issues CS# assert, 3 CA words, 1 data word (zero latency), CS# hold,
// CS# high recovery, then holds stm_end until stm_start drops.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hbus_wrreg_seq_if.slave (handshake, CA/data in, pad controls out)
// Optional: define HBUS_WRREG_CACHK_EN to reject CA words that are not
// register-space writes (bus untouched, stm_end with err=1).
// All outputs are registered from the next state, so they change on the
// same edge as the state itself.
module hbus_wrreg_seq
    import hbus_pkg::*;
#(
    parameter int DW       = HBUS_DW,
    parameter int CAW      = HBUS_CAW,
    parameter int CSS_CYC  = 1,
    parameter int CSHI_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    hbus_wrreg_seq_if.slave   bus
);

    localparam int CW = cyc_cnt_w(CSS_CYC, CSHI_CYC);

    logic [3:0]     state, nxt;
    logic           start_q;
    logic           launch;
    logic           ca_bad;
    logic [CAW-1:0] ca_r, ca_src;
    logic [DW-1:0]  wd_r;

    logic           cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]  cnt_val;

    logic           csn_d, oe_d, ck_d, end_d;
    logic [DW-1:0]  dat_d;
    logic           csn_q, oe_q, ck_q, end_q;
    logic [DW-1:0]  dat_q;

    assign launch = bus.stm_start && !start_q;

`ifdef HBUS_WRREG_CACHK_EN
    assign ca_bad = !ca_reg_wr_ok(bus.casig);
`else
    assign ca_bad = 1'b0;
`endif

    // CSS outputs are registered on the launch edge, before ca_r holds the
    // captured word, so take the first CA word straight from the input then.
    assign ca_src = (state == ST_IDLE) ? bus.casig : ca_r;

    hbus_cyc_cnt #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .ld_val (cnt_val),
        .dec    (cnt_dec),
        .zero   (cnt_zero)
    );

    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: if (launch) begin
                if (ca_bad) begin
                    nxt = ST_DONE;
                end else begin
                    nxt      = ST_CSS;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(CSS_CYC - 1);
                end
            end
            ST_CSS:  if (cnt_zero) nxt = ST_CA0; else cnt_dec = 1'b1;
            ST_CA0:  nxt = ST_CA1;
            ST_CA1:  nxt = ST_CA2;
            ST_CA2:  nxt = ST_DATA;
            ST_DATA: nxt = ST_HOLD;
            ST_HOLD: begin
                nxt      = ST_CSHI;
                cnt_load = 1'b1;
                cnt_val  = CW'(CSHI_CYC - 1);
            end
            ST_CSHI: if (cnt_zero) nxt = ST_DONE; else cnt_dec = 1'b1;
            ST_DONE: if (!bus.stm_start) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        csn_d = 1'b1;
        oe_d  = 1'b0;
        ck_d  = 1'b0;
        end_d = 1'b0;
        dat_d = '0;
        case (nxt)
            ST_CSS:  begin csn_d = 1'b0; oe_d = 1'b1; dat_d = ca_src[CAW-1 -: DW]; end
            ST_CA0:  begin csn_d = 1'b0; oe_d = 1'b1; ck_d = 1'b1; dat_d = ca_src[CAW-1 -: DW]; end
            ST_CA1:  begin csn_d = 1'b0; oe_d = 1'b1; ck_d = 1'b1; dat_d = ca_r[2*DW-1 -: DW]; end
            ST_CA2:  begin csn_d = 1'b0; oe_d = 1'b1; ck_d = 1'b1; dat_d = ca_r[DW-1:0]; end
            ST_DATA: begin csn_d = 1'b0; oe_d = 1'b1; ck_d = 1'b1; dat_d = wd_r; end
            ST_HOLD: csn_d = 1'b0;   // CS# held one cycle past the last CK
            ST_DONE: end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            ca_r    <= '0;
            wd_r    <= '0;
            csn_q   <= 1'b1;
            oe_q    <= 1'b0;
            ck_q    <= 1'b0;
            end_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state   <= nxt;
            start_q <= bus.stm_start;
            if (state == ST_IDLE && launch) begin
                ca_r <= bus.casig;
                wd_r <= bus.wrdata;
            end
            csn_q   <= csn_d;
            oe_q    <= oe_d;
            ck_q    <= ck_d;
            end_q   <= end_d;
            dat_q   <= dat_d;
        end
    end

`ifdef HBUS_WRREG_CACHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (state == ST_IDLE && launch)
            err_q <= ca_bad;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.csn     = csn_q;
    assign bus.oe      = oe_q;
    assign bus.oe_clk  = ck_q;
    assign bus.stm_end = end_q;
    assign bus.datain  = dat_q;

endmodule
